// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator: two line buffers plus a 3-column shift window.
// Turns a raster pixel stream into registered 3x3 neighbourhoods for the kernel stages.
module window_3x3_gen #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] lu,
  output logic [7:0] cu,
  output logic [7:0] ru,
  output logic [7:0] lc,
  output logic [7:0] cc,
  output logic [7:0] rc,
  output logic [7:0] lb,
  output logic [7:0] cb,
  output logic [7:0] rb,
  output logic       win_valid,
  output logic       eof_out
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColTwo  = CW'(2);
  localparam logic [RW-1:0] RowTwo  = RW'(2);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          win_d, eof_d;
  logic          win_valid_q, eof_q;
  logic [7:0]    lb1_rd, lb2_rd;

  logic [7:0] lu_q, cu_q, ru_q, lc_q, cc_q, rc_q, lb_q, cb_q, rb_q;

  // Line buffers: LB1 holds the previous line, LB2 the line before that.
  logic [7:0] lb1_mem [IMG_W];
  logic [7:0] lb2_mem [IMG_W];

  // Position of the incoming pixel; sof forces (0,0) whatever the counters say.
  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    lb1_rd  = lb1_mem[cur_col];
    lb2_rd  = lb2_mem[cur_col];
  end

  // Counter advance and window-valid decode for an accepted pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = 1'b0;
    eof_d = 1'b0;
    if (pix_valid) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      win_d = (cur_row >= RowTwo) && (cur_col >= ColTwo);
      eof_d = (cur_row == RowLast) && (cur_col == ColLast);
    end
  end

  // Line-buffer RAM update, read-before-write at the same address; never reset.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2_mem[cur_col] <= lb1_rd;
      lb1_mem[cur_col] <= pix_in;
    end
  end

  // Counters, flags and 3-column window shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      eof_q       <= 1'b0;
      lu_q <= '0; cu_q <= '0; ru_q <= '0;
      lc_q <= '0; cc_q <= '0; rc_q <= '0;
      lb_q <= '0; cb_q <= '0; rb_q <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_d;
      eof_q       <= eof_d;
      if (pix_valid) begin
        lu_q <= cu_q; cu_q <= ru_q; ru_q <= lb2_rd;
        lc_q <= cc_q; cc_q <= rc_q; rc_q <= lb1_rd;
        lb_q <= cb_q; cb_q <= rb_q; rb_q <= pix_in;
      end
    end
  end

  assign lu = lu_q;
  assign cu = cu_q;
  assign ru = ru_q;
  assign lc = lc_q;
  assign cc = cc_q;
  assign rc = rc_q;
  assign lb = lb_q;
  assign cb = cb_q;
  assign rb = rb_q;
  assign win_valid = win_valid_q;
  assign eof_out   = eof_q;

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Converts a raster-order 8-bit grayscale pixel stream into a registered 3x3 neighbourhood (lu..rb) for the 3x3 kernel stages (Gaussian blur, then edge detection).
- Holds two line buffers of IMG_W pixels plus a 3-column shift window.
- Emits one window per accepted pixel once the window lies fully inside the frame (no border padding).
- Sits directly upstream of the blur stage; its nine window outputs connect one-to-one to the blur inputs.

Parameters:
- IMG_W, 640, pixels per line (>= 3).
- IMG_H, 480, lines per frame (>= 3).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- pix_in  input  8  incoming pixel, raster order
- pix_valid  input  1  pix_in valid this cycle; pixel accepted when high (no backpressure)
- sof  input  1  start of frame; qualified by pix_valid; marks pixel (0,0)
- lu, cu, ru  output  8 each  window top row: left, centre, right
- lc, cc, rc  output  8 each  window middle row
- lb, cb, rb  output  8 each  window bottom row
- win_valid  output  1  window outputs valid this cycle
- eof_out  output  1  pulses with the last window of a frame

Behaviour:
- Reset: synchronous, active-high, applied on the clk edge.
  - Column counter col and row counter row go to 0.
  - All nine window regs go to 0x00; win_valid and eof_out go to 0.
  - Line-buffer RAM is not reset.
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1, each $clog2 width. They advance only on accepted pixels.
  - col wraps to 0 and row increments at col==IMG_W-1.
  - row wraps to 0 after (IMG_H-1, IMG_W-1), i.e. implicit next frame.
- Pixel position: an accepted pixel with sof=1 is position (0,0) regardless of counter state; the counters then become col=1, row=0. sof without pix_valid is ignored.
- On an accepted pixel P at position (r,c), all updates take effect in the same edge:
  - New column: top=LB2[c], mid=LB1[c], bottom=P.
  - Window shift: left column <= centre column, centre column <= right column, right column <= new column. So ru=LB2[c], rc=LB1[c], rb=P.
  - Line buffers: LB2[c] <= LB1[c], LB1[c] <= P (read-before-write at the same address).
- Output timing: win_valid=1 in the cycle after acceptance iff r>=2 and c>=2, so latency is 1 clock.
  - The window is then centred on pixel (r-1, c-1).
  - It equals the frame pixels rows r-2..r and columns c-2..c, with no mixing across line boundaries.
- Window count: (IMG_W-2)*(IMG_H-2) windows per frame.
- eof_out=1 together with win_valid for the window produced by pixel (IMG_H-1, IMG_W-1); otherwise 0.
- Idle cycles (pix_valid=0): win_valid=0 and eof_out=0. Window regs hold their values. Gaps of any length are allowed anywhere, including mid-line.
- Frame start: windows at rows 0-1 of a new frame are never emitted, so stale line-buffer data is never visible.
- sof mid-frame: the frame is abandoned with no eof_out, and counting restarts at (0,0). The first window afterwards comes from the new frame's pixel (2,2).
- rst mid-frame: the next valid window requires a full new 2-line fill. A pixel after reset without sof is treated as (0,0).
- Structure: line buffers are inferrable single-port-style RAM (one read plus one write at the same address per cycle), depth IMG_W. No combinational path from inputs to outputs.

Test Plan (IMG_W=5, IMG_H=4; pixel value = 16*row + col unless noted):
- Continuous frame after reset, sof on the first pixel -> first win_valid the cycle after pixel (2,2) with lu=00 cu=01 ru=02 lc=10 cc=11 rc=12 lb=20 cb=21 rb=22; exactly 6 windows total; last window rb=0x34 with eof_out=1.
- Same frame with random 0-3 cycle pix_valid gaps -> identical 6 windows in order; win_valid never high on idle cycles; outputs hold between windows.
- Line-boundary check -> no window after pixels (2,0) or (2,1); the window after (3,2) has lu=10, rb=32.
- Two back-to-back frames, second frame value = 0x80 + 16*row + col, sof on each -> frame-2 windows contain only 0x8x/0x9x/0xAx/0xBx values; 6 windows and one eof_out per frame.
- sof asserted at pixel (2,3) of frame 1, then a full frame 2 -> no eof_out for frame 1; next window after frame-2 pixel (2,2) equals frame-2 data only.
- rst asserted mid-row 3, then a full frame -> outputs 0 and win_valid=0 the cycle after rst; exactly 6 correct windows follow.
